// File: rtl/pmodstep_step_sequencer_pkg.sv
// Shared types and constants for the PmodSTEP step sequencer: FSM states,
// the 8-entry coil drive table and the index stepping rule.
package pmodstep_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Entry i sits at bit slice [i]; even entries energise two coils.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    localparam logic [2:0] STRIDE_FULL = 3'd2;
    localparam logic [2:0] STRIDE_HALF = 3'd1;

    // Full step from an odd index lands on the nearest even entry in the
    // direction of travel; from an even index it moves two entries.
    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
        logic [2:0] n;
        if (half) begin
            n = dir ? idx + STRIDE_HALF : idx - STRIDE_HALF;
        end else begin
            n    = dir ? idx + STRIDE_FULL : idx - STRIDE_HALF;
            n[0] = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/pmodstep_step_sequencer_if.sv
// Command/status bundle between the AXI4-Lite register file (master) and the
// step sequencer (slave), including the coil drive lines.
interface pmodstep_step_sequencer_if #(
    parameter int CNT_W   = 32,
    parameter int STEPS_W = 16
);
    logic [CNT_W-1:0]   cfg_period;
    logic [STEPS_W-1:0] cfg_steps;
    logic               cfg_dir;
    logic               cfg_half;
    logic               cfg_hold;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic [STEPS_W-1:0] steps_left;
    logic [3:0]         phase;

    modport master (
        output cfg_period, cfg_steps, cfg_dir, cfg_half, cfg_hold, start, abort,
        input  busy, done, steps_left, phase
    );

    modport slave (
        input  cfg_period, cfg_steps, cfg_dir, cfg_half, cfg_hold, start, abort,
        output busy, done, steps_left, phase
    );
endinterface

// File: rtl/pmodstep_phase_lut.sv
// Combinational lookup from 3-bit sequence index to {A+,B+,A-,B-} coil drive.
module pmodstep_phase_lut
    import pmodstep_pkg::*;
(
    input  logic [2:0] idx,
    output logic [3:0] phase
);
    assign phase = PHASE_TABLE[idx];
endmodule

// File: rtl/pmodstep_step_sequencer.sv
// Timed stepper sequencer driving the four PmodSTEP coil lines.
// Optional half-stepping is enabled with `define PMODSTEP_HALF_STEP_EN.
module pmodstep_step_sequencer
    import pmodstep_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STEPS_W = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    pmodstep_step_sequencer_if.slave bus
);

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   reload_q, reload_d;
    logic [STEPS_W-1:0] steps_left_q, steps_left_d;
    logic               dir_q, dir_d;
    logic               half_q, half_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         phase_q, phase_d;
    logic [3:0]         lut_phase;
    logic [CNT_W-1:0]   load_val;

    // A zero period behaves as one cycle per step.
    assign load_val = (bus.cfg_period == '0) ? '0 : bus.cfg_period - CNT_W'(1);

`ifdef PMODSTEP_HALF_STEP_EN
    logic cfg_half_sel;
    assign cfg_half_sel = bus.cfg_half;
`else
    logic cfg_half_sel;
    logic unused_cfg_half;
    assign cfg_half_sel    = 1'b0;
    assign unused_cfg_half = bus.cfg_half;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        reload_d     = reload_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        half_d       = half_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    dir_d        = bus.cfg_dir;
                    half_d       = cfg_half_sel;
                    steps_left_d = bus.cfg_steps;
                    cnt_d        = load_val;
                    reload_d     = load_val;
                    if (bus.cfg_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Abort takes priority over a step due in the same cycle.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    idx_d        = next_idx(idx_q, dir_q, half_q);
                    steps_left_d = steps_left_q - STEPS_W'(1);
                    cnt_d        = reload_q;
                    if (steps_left_q == STEPS_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifndef PMODSTEP_HALF_STEP_EN
        idx_d[0] = 1'b0;
`endif

        busy_d  = (state_d == ST_RUN);
        phase_d = (busy_d || bus.cfg_hold) ? lut_phase : 4'b0000;
    end

    pmodstep_phase_lut u_lut (
        .idx   (idx_d),
        .phase (lut_phase)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            reload_q     <= '0;
            steps_left_q <= '0;
            dir_q        <= 1'b0;
            half_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            phase_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            reload_q     <= reload_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            half_q       <= half_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            phase_q      <= phase_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.steps_left = steps_left_q;
    assign bus.phase      = phase_q;

endmodule

// File: tb/tb_pmodstep_step_sequencer.sv
// Self-checking bench: directed move table, random moves against an arithmetic
// model of step timing and table position, plus reset and start/abort corners.
module tb_pmodstep_step_sequencer;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    pmodstep_step_sequencer_if bus ();

    pmodstep_step_sequencer dut (
        .ACLK    (aclk),
        .ARESETN (aresetn),
        .bus     (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    int model_idx = 0;
    logic [3:0] tbl [8] = '{4'b1001, 4'b1000, 4'b1100, 4'b0100,
                            4'b0110, 4'b0010, 4'b0011, 4'b0001};

    typedef struct {
        int         period;
        int         steps;
        bit         dir;
        bit         hold;
        bit         half;
        int         abort_at;
        logic [3:0] exp_phase;
        int         exp_left;
        int         exp_end;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Table position after s steps from idx0, from the stepping rules alone.
    function automatic int adv(input int idx0, input int s, input bit dir, input bit half);
        int e;
        if (s == 0) return idx0;
        if (half) return dir ? (idx0 + s) % 8 : (((idx0 - s) % 8) + 8) % 8;
        if (dir) e = (idx0 / 2 + s) % 4;
        else     e = ((((idx0 + 1) / 2 - s) % 4) + 4) % 4;
        return 2 * e;
    endfunction

    task automatic run_move(input int period, input int steps, input bit dir,
                            input bit hold, input bit half, input int abort_at,
                            input int restart_at, output logic [3:0] fin_phase,
                            output int fin_left, output int done_k);
        int peff, k_end, s_fin, s, idx0, idx;
        bit eff_half, e_busy, e_done;
        logic [3:0] e_phase;
`ifdef PMODSTEP_HALF_STEP_EN
        eff_half = half;
`else
        eff_half = 1'b0;
`endif
        peff = (period == 0) ? 1 : period;
        idx0 = model_idx;
        if (steps == 0) begin
            k_end = 0; s_fin = 0;
        end else if (abort_at >= 0 && abort_at < steps * peff) begin
            k_end = abort_at + 1; s_fin = abort_at / peff;
        end else begin
            k_end = steps * peff; s_fin = steps;
        end
        done_k = -1; fin_phase = 4'bx; fin_left = -1;

        bus.cfg_period = 32'(period);
        bus.cfg_steps  = 16'(steps);
        bus.cfg_dir    = dir;
        bus.cfg_half   = half;
        bus.cfg_hold   = hold;
        bus.start      = 1'b1;
        bus.abort      = 1'b0;
        tick();
        bus.start = 1'b0;
        // Shadowed fields must not influence the move in progress.
        bus.cfg_period = $urandom_range(0, 7);
        bus.cfg_steps  = 16'($urandom_range(0, 9));
        bus.cfg_dir    = 1'($urandom);
        bus.cfg_half   = 1'($urandom);

        for (int k = 0; k <= k_end + 1; k++) begin
            if (k < k_end) begin
                s = (k / peff < steps) ? k / peff : steps;
                e_busy = 1'b1; e_done = 1'b0;
            end else begin
                s = s_fin;
                e_busy = 1'b0; e_done = (k == k_end);
            end
            idx = adv(idx0, s, dir, eff_half);
            e_phase = (e_busy || hold) ? tbl[idx] : 4'b0000;
            chk($sformatf("phase k=%0d", k), 32'(bus.phase), 32'(e_phase));
            chk($sformatf("busy k=%0d", k), 32'(bus.busy), 32'(e_busy));
            chk($sformatf("done k=%0d", k), 32'(bus.done), 32'(e_done));
            chk($sformatf("steps_left k=%0d", k), 32'(bus.steps_left), 32'(steps - s));
            if (bus.done === 1'b1 && done_k < 0) done_k = k;
            if (k == k_end) begin
                fin_phase = bus.phase;
                fin_left  = int'(bus.steps_left);
            end
            bus.abort = (k == abort_at) && (k < k_end);
            bus.start = (k == restart_at) && (k < k_end);
            tick();
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        model_idx = adv(idx0, s_fin, dir, eff_half);
        $display("move P=%0d N=%0d dir=%0d half=%0d hold=%0d abort_at=%0d -> left=%0d done@%0d",
                 period, steps, dir, half, hold, abort_at, fin_left, done_k);
    endtask

    initial begin
        logic [3:0] fp;
        int fl, dk;

        vecs[0] = '{4,  3, 1'b1, 1'b1, 1'b0, -1, 4'b0011, 0, 12};
        vecs[1] = '{2,  1, 1'b1, 1'b1, 1'b0, -1, 4'b1001, 0, 2};
        vecs[2] = '{3,  2, 1'b0, 1'b1, 1'b0, -1, 4'b0110, 0, 6};
        vecs[3] = '{5,  0, 1'b1, 1'b0, 1'b0, -1, 4'b0000, 0, 0};
        vecs[4] = '{10, 5, 1'b1, 1'b0, 1'b0, 21, 4'b0000, 3, 22};
        vecs[5] = '{0,  8, 1'b1, 1'b1, 1'b1, -1, 4'b1001, 0, 8};
`ifdef PMODSTEP_HALF_STEP_EN
        vecs[6] = '{1,  3, 1'b0, 1'b1, 1'b1, -1, 4'b0010, 0, 3};
        vecs[7] = '{2,  1, 1'b1, 1'b1, 1'b0, -1, 4'b0011, 0, 2};
`else
        vecs[6] = '{1,  3, 1'b0, 1'b1, 1'b1, -1, 4'b1100, 0, 3};
        vecs[7] = '{2,  1, 1'b1, 1'b1, 1'b0, -1, 4'b0110, 0, 2};
`endif

        bus.cfg_period = '0; bus.cfg_steps = '0; bus.cfg_dir = 1'b0;
        bus.cfg_half = 1'b0; bus.cfg_hold = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) tick();
        chk("reset phase", 32'(bus.phase), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset done", 32'(bus.done), 32'h0);
        chk("reset steps_left", 32'(bus.steps_left), 32'h0);
        aresetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_move(vecs[i].period, vecs[i].steps, vecs[i].dir, vecs[i].hold,
                     vecs[i].half, vecs[i].abort_at, -1, fp, fl, dk);
            chk($sformatf("vec%0d final phase", i), 32'(fp), 32'(vecs[i].exp_phase));
            chk($sformatf("vec%0d final left", i), 32'(fl), 32'(vecs[i].exp_left));
            chk($sformatf("vec%0d done cycle", i), 32'(dk), 32'(vecs[i].exp_end));
        end

        for (int i = 0; i < 25; i++) begin
            int p, n, ab, rs;
            p  = $urandom_range(0, 5);
            n  = $urandom_range(0, 6);
            ab = ($urandom_range(0, 9) < 3 && n > 0) ?
                 $urandom_range(0, n * ((p == 0) ? 1 : p) - 1) : -1;
            rs = $urandom_range(0, 12);
            run_move(p, n, 1'($urandom), 1'($urandom), 1'($urandom), ab, rs, fp, fl, dk);
        end

        // start and abort together while idle: abort wins, nothing moves.
        bus.cfg_hold = 1'b1; bus.cfg_steps = 16'd5; bus.cfg_period = 32'd2;
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("start+abort busy", 32'(bus.busy), 32'h0);
        chk("start+abort done", 32'(bus.done), 32'h0);
        chk("start+abort phase", 32'(bus.phase), 32'(tbl[model_idx]));
        tick();
        chk("start+abort busy later", 32'(bus.busy), 32'h0);
        $display("start+abort idle: busy=%0d done=%0d", bus.busy, bus.done);

        // Asynchronous reset in the middle of a move.
        bus.cfg_hold = 1'b0; bus.cfg_steps = 16'd10; bus.cfg_period = 32'd3;
        bus.cfg_dir = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("pre-reset busy", 32'(bus.busy), 32'h1);
        #2 aresetn = 1'b0;
        #1;
        chk("async reset phase", 32'(bus.phase), 32'h0);
        chk("async reset busy", 32'(bus.busy), 32'h0);
        chk("async reset steps_left", 32'(bus.steps_left), 32'h0);
        tick();
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post-reset done k=%0d", k), 32'(bus.done), 32'h0);
            chk($sformatf("post-reset busy k=%0d", k), 32'(bus.busy), 32'h0);
        end
        model_idx = 0;
        bus.cfg_hold = 1'b1;
        tick();
        chk("hold idle phase", 32'(bus.phase), 32'(tbl[0]));
        $display("reset mid-run: phase=%b busy=%0d", bus.phase, bus.busy);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
